// File: rtl/axi_lite_port_arbiter.sv
// axi_lite_port_arbiter: shares one AXI-Lite master interface between the
// instruction-fetch read port (IF) and the memory-stage read/write port (MEM).
// Grants one transaction at a time, pulses the master's enable for one cycle,
// waits for read-ready / write-over, and returns a one-cycle done pulse to the
// granted requester. Transactions that never complete are retired with an
// error flag after TIMEOUT_CYCLES busy cycles.
// Build option: define ARB_ROUND_ROBIN_EN to alternate IF and MEM on conflict;
// otherwise fixed priority MemWriteReq > MemReadReq > IfReadReq.
module axi_lite_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              IfReadReq,
  input  logic [ADDR_W-1:0] IfReadAddr,
  output logic [DATA_W-1:0] IfReadData,
  output logic              IfReadDone,
  output logic              IfReadErr,
  input  logic              MemReadReq,
  input  logic              MemWriteReq,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemWriteData,
  input  logic [3:0]        MemWriteMask,
  output logic [DATA_W-1:0] MemReadData,
  output logic              MemDone,
  output logic              MemErr,
  output logic              ReadEnableOut,
  output logic              WriteEnableOut,
  output logic [ADDR_W-1:0] ReadAddrOut,
  output logic [ADDR_W-1:0] WriteAddrOut,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic [3:0]        WriteMaskOut,
  input  logic [DATA_W-1:0] ReadDataIn,
  input  logic              ReadDataReadyIn,
  input  logic              WriteDataOverIn,
  output logic              Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_IF_RD, S_MEM_RD, S_MEM_WR, S_RESP
  } state_t;

  // Counter is sized for the largest legal TIMEOUT_CYCLES (65535).
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [3:0]          wr_mask_q, wr_mask_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d, mem_data_q, mem_data_d;
  logic                if_done_q, if_done_d, if_err_q, if_err_d;
  logic                mem_done_q, mem_done_d, mem_err_q, mem_err_d;
  logic                busy_q, busy_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic                last_mem_q, last_mem_d;  // 1: MEM was granted last
`endif

  logic mem_req, grant_mem, grant_if, rsp, timed_out;

  // Next-state, grant and response routing for every registered output.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_mask_d  = wr_mask_q;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    mem_done_d = 1'b0;
    mem_err_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_mem_d = last_mem_q;
`endif

    mem_req = MemWriteReq | MemReadReq;
`ifdef ARB_ROUND_ROBIN_EN
    // On a conflict the side not granted last time wins.
    grant_mem = mem_req && (!IfReadReq || !last_mem_q);
`else
    grant_mem = mem_req;
`endif
    grant_if  = IfReadReq && !grant_mem;

    // Only the indication belonging to the current busy state counts.
    rsp       = (state_q == S_MEM_WR) ? WriteDataOverIn : ReadDataReadyIn;
    timed_out = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (grant_mem) begin
          if (MemWriteReq) begin
            state_d   = S_MEM_WR;
            wr_en_d   = 1'b1;
            wr_addr_d = MemAddr;
            wr_data_d = MemWriteData;
            wr_mask_d = MemWriteMask;
          end else begin
            state_d   = S_MEM_RD;
            rd_en_d   = 1'b1;
            rd_addr_d = MemAddr;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_mem_d = 1'b1;
`endif
        end else if (grant_if) begin
          state_d   = S_IF_RD;
          rd_en_d   = 1'b1;
          rd_addr_d = IfReadAddr;
`ifdef ARB_ROUND_ROBIN_EN
          last_mem_d = 1'b0;
`endif
        end
      end
      S_IF_RD, S_MEM_RD, S_MEM_WR: begin
        if (rsp || timed_out) begin
          // A response in the timeout cycle wins over the error.
          state_d = S_RESP;
          cnt_d   = '0;
          if (state_q == S_IF_RD) begin
            if_done_d = 1'b1;
            if_err_d  = !rsp;
            if_data_d = rsp ? ReadDataIn : '0;
          end else begin
            mem_done_d = 1'b1;
            mem_err_d  = !rsp;
            if (state_q == S_MEM_RD) mem_data_d = rsp ? ReadDataIn : '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d   = S_IDLE;
        rd_addr_d = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        wr_mask_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_mask_q  <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      mem_done_q <= 1'b0;
      mem_err_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_mask_q  <= wr_mask_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      mem_done_q <= mem_done_d;
      mem_err_q  <= mem_err_d;
      busy_q     <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem_q <= last_mem_d;
`endif
    end
  end

  assign IfReadData     = if_data_q;
  assign IfReadDone     = if_done_q;
  assign IfReadErr      = if_err_q;
  assign MemReadData    = mem_data_q;
  assign MemDone        = mem_done_q;
  assign MemErr         = mem_err_q;
  assign ReadEnableOut  = rd_en_q;
  assign WriteEnableOut = wr_en_q;
  assign ReadAddrOut    = rd_addr_q;
  assign WriteAddrOut   = wr_addr_q;
  assign WriteDataOut   = wr_data_q;
  assign WriteMaskOut   = wr_mask_q;
  assign Busy           = busy_q;

endmodule

// File: doc/axi_lite_port_arbiter.md
Name: axi_lite_port_arbiter

Overview:
Shares the single AXI-Lite master interface between the instruction-fetch read requester (IF) and the memory-stage read/write requester (MEM). Sits between the pipeline and the master interface. Drives the interface's one-cycle enable/address/data inputs and waits for its read-data-ready or write-done indication. Routes the response back to the granted requester and retires transactions that never complete via a timeout.

Parameters:
ADDR_W, 64, address width (matches AddrBus)
DATA_W, 64, data width (matches DataBus)
TIMEOUT_CYCLES, 1024, max busy cycles before forced error completion; legal 2..65535

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
IfReadReq  in  1  IF read request, held until IfReadDone
IfReadAddr  in  ADDR_W  IF read address
IfReadData  out  DATA_W  IF read data, valid with IfReadDone
IfReadDone  out  1  one-cycle IF completion pulse
IfReadErr  out  1  IF timeout flag, valid with IfReadDone
MemReadReq  in  1  MEM read request, held until MemDone
MemWriteReq  in  1  MEM write request, held until MemDone
MemAddr  in  ADDR_W  MEM address
MemWriteData  in  DATA_W  MEM write data
MemWriteMask  in  4  MEM write strobes
MemReadData  out  DATA_W  MEM read data, valid with MemDone
MemDone  out  1  one-cycle MEM completion pulse
MemErr  out  1  MEM timeout flag, valid with MemDone
ReadEnableOut  out  1  to master interface ReadEnableIn
WriteEnableOut  out  1  to master interface WriteEnableIn
ReadAddrOut  out  ADDR_W  to ReadAddrIn
WriteAddrOut  out  ADDR_W  to WriteAddrIn
WriteDataOut  out  DATA_W  to WriteDataIn
WriteMaskOut  out  4  to WriteMask
ReadDataIn  in  DATA_W  from ReadDataOut
ReadDataReadyIn  in  1  from ReadDataReady
WriteDataOverIn  in  1  from WriteDataOver
Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, ARESETn low): state IDLE; all outputs 0; timeout counter 0; round-robin pointer (if built) points to IF. An in-flight transaction is dropped and no done pulse is issued.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, RESP. All outputs are registered.
- IDLE: arbitrate on the sampled requests.
  - Fixed priority: MemWriteReq > MemReadReq > IfReadReq.
  - MemWriteReq and MemReadReq both high: write wins; read stays pending.
  - On grant, latch address, data and mask into the output registers and go to IF_RD, MEM_RD or MEM_WR.
  - The matching ReadEnableOut or WriteEnableOut is high for exactly the first cycle of the busy state, then low.
  - Latency: request sampled at edge N gives enable high in cycle N+1.
- Address/data/mask outputs hold their latched values for the whole busy state and are cleared to 0 on return to IDLE.
- IF_RD / MEM_RD: wait for ReadDataReadyIn.
  - On ReadDataReadyIn, capture ReadDataIn into IfReadData or MemReadData and go to RESP.
- MEM_WR: wait for WriteDataOverIn, then go to RESP.
- A ready/over indication arriving in IDLE or RESP is ignored.
- Timeout: the counter increments each busy cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with no response, go to RESP with the error flag set and read data 0.
  - A response arriving in that same cycle wins: no error is flagged.
  - The counter clears on entering RESP.
- RESP: lasts exactly one cycle.
  - IfReadDone or MemDone is high for that one cycle, and the matching Err is valid alongside it.
  - The next state is always IDLE.
  - Requesters must deassert by the edge ending RESP. A request still high in IDLE is treated as a new request.
- Data outputs hold their last value until the next completion to the same requester.
- Back-to-back: one IDLE cycle between transactions. Minimum transaction is 4 cycles: IDLE, busy, RESP, IDLE.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: IF and MEM (either type) alternate on conflict.
  - A 1-bit pointer records the last granted side.
  - On simultaneous requests, the other side wins.
  - MEM write still beats MEM read within the MEM side.
- Undefined: fixed priority as above; the pointer logic is absent.

Test Plan:
- IfReadReq=1, IfReadAddr=0x80000000; ReadDataReadyIn pulsed 3 cycles after ReadEnableOut with ReadDataIn=0xDEADBEEF -> ReadEnableOut is a one-cycle pulse with ReadAddrOut=0x80000000; IfReadDone is a one-cycle pulse with IfReadData=0xDEADBEEF and IfReadErr=0.
- MemWriteReq=1, MemAddr=0x80001000, MemWriteData=0x1234, MemWriteMask=4'hF, WriteDataOverIn pulsed -> WriteEnableOut is one cycle with matching address/data/mask; MemDone pulses; WriteDataOut is cleared to 0 in IDLE.
- IfReadReq and MemReadReq asserted in the same cycle, both held -> MEM served first, then IF. With ARB_ROUND_ROBIN_EN and IF held continuously, grants alternate MEM, IF, MEM.
- MemReadReq, TIMEOUT_CYCLES=8, no ReadDataReadyIn -> MemDone with MemErr=1 and MemReadData=0 exactly 8 busy cycles after grant; returns to IDLE.
- ARESETn pulled low mid-MEM_WR -> all outputs 0 immediately, Busy=0, and no MemDone after release.
